// File: rtl/xm_run_controller.sv
// Debug run-control sequencer: free-run, single/N-step and PC-breakpoint halts,
// always stopping the CPU on an instruction boundary.
module xm_run_controller #(
   parameter int PC_W  = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             step_i,
   input  logic [CNT_W-1:0] step_count_i,
   input  logic             bp_en_i,
   input  logic [PC_W-1:0]  bp_addr_i,
   input  logic [PC_W-1:0]  pc_i,
   input  logic             instr_done_i,
   output logic             halt_o,
   output logic             view_o,
   output logic             bp_hit_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   typedef enum logic [1:0] {
      ST_HALTED  = 2'd0,
      ST_STEP    = 2'd1,
      ST_RUN     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bp_hit_q, bp_hit_d;
   logic             step_q, step_d;
   logic             step_rise, bp_match;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      cnt_d       = cnt_q;
      bp_hit_d    = bp_hit_q;
      step_d      = step_i;
      step_rise   = step_i & ~step_q;
      bp_match    = bp_en_i & instr_done_i & (pc_i == bp_addr_i);
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

      case (state_q)
         ST_HALTED: begin
            if (step_rise) begin
               state_d     = ST_STEP;
               remaining_d = (step_count_i == '0) ? CNT_ONE : step_count_i;
               bp_hit_d    = 1'b0;
               cnt_d       = '0;
            end else if (run_i) begin
               state_d  = ST_RUN;
               bp_hit_d = 1'b0;
               cnt_d    = '0;
            end
         end
         ST_STEP: begin
            if (instr_done_i) begin
               remaining_d = remaining_q - CNT_ONE;
               cnt_d       = cnt_inc;
               if (bp_match) begin
                  state_d  = ST_RELEASE;
                  bp_hit_d = 1'b1;
               end else if (remaining_q == CNT_ONE) begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RUN: begin
            if (instr_done_i) begin
               cnt_d = cnt_inc;
               if (bp_match) begin
                  state_d  = ST_RELEASE;
                  bp_hit_d = 1'b1;
               end else if (!run_i) begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            // Wait for button and switch to be let go so a held input cannot re-trigger.
            if (!(step_i | run_i)) state_d = ST_HALTED;
         end
         default: state_d = ST_HALTED;
      endcase
   end

   // step_q resets high so a button held through reset does not count as a press.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_HALTED;
         remaining_q <= '0;
         cnt_q       <= '0;
         bp_hit_q    <= 1'b0;
         step_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         cnt_q       <= cnt_d;
         bp_hit_q    <= bp_hit_d;
         step_q      <= step_d;
      end
   end

   assign halt_o      = (state_q == ST_HALTED) || (state_q == ST_RELEASE);
   assign view_o      = (state_q == ST_HALTED);
   assign bp_hit_o    = bp_hit_q;
   assign state_o     = state_q;
   assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_xm_run_controller.sv
// Self-checking bench for xm_run_controller: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_xm_run_controller;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        run_i;
   logic        step_i;
   logic [7:0]  step_count_i;
   logic        bp_en_i;
   logic [15:0] bp_addr_i;
   logic [15:0] pc_i;
   logic        instr_done_i;
   logic        halt_o;
   logic        view_o;
   logic        bp_hit_o;
   logic [1:0]  state_o;
   logic [7:0]  instr_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   xm_run_controller #(.PC_W(16), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .step_i(step_i),
      .step_count_i(step_count_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
      .pc_i(pc_i), .instr_done_i(instr_done_i), .halt_o(halt_o), .view_o(view_o),
      .bp_hit_o(bp_hit_o), .state_o(state_o), .instr_cnt_o(instr_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural model: mode 0=halted 1=stepping 2=running 3=waiting for release
   int m_mode;
   int m_left;
   int m_cnt;
   bit m_bp;
   bit m_prev_step;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_cnt = 0; m_bp = 0; m_prev_step = 1;
   endtask

   task automatic model_clk(input bit run, input bit step, input int cnt, input bit bpen,
                            input int bpa, input int pc, input bit done);
      bit press;
      bit hit;
      press = step && !m_prev_step;
      hit   = bpen && done && (pc == bpa);
      if (m_mode == 0) begin
         if (press) begin
            m_mode = 1; m_left = (cnt == 0) ? 1 : cnt; m_bp = 0; m_cnt = 0;
         end else if (run) begin
            m_mode = 2; m_bp = 0; m_cnt = 0;
         end
      end else if (m_mode == 1 || m_mode == 2) begin
         if (done) begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_mode == 1) m_left = m_left - 1;
            if (hit) begin
               m_mode = 3; m_bp = 1;
            end else if ((m_mode == 1 && m_left == 0) || (m_mode == 2 && !run)) begin
               m_mode = 3;
            end
         end
      end else if (!(step || run)) begin
         m_mode = 0;
      end
      m_prev_step = step;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".state"}, state_o, m_mode);
      check({tag, ".halt"}, halt_o, (m_mode == 0 || m_mode == 3) ? 1 : 0);
      check({tag, ".view"}, view_o, (m_mode == 0) ? 1 : 0);
      check({tag, ".bp_hit"}, bp_hit_o, m_bp);
      check({tag, ".cnt"}, instr_cnt_o, m_cnt);
   endtask

   // Called right after a negedge: drive, advance the model, sample at the next negedge.
   task automatic apply(input string tag, input bit run, input bit step, input int cnt,
                        input bit bpen, input int bpa, input int pc, input bit done);
      run_i = run; step_i = step; step_count_i = cnt[7:0]; bp_en_i = bpen;
      bp_addr_i = bpa[15:0]; pc_i = pc[15:0]; instr_done_i = done;
      model_clk(run, step, cnt, bpen, bpa, pc, done);
      @(negedge clk_i);
      check_model(tag);
   endtask

   task automatic do_reset(input bit hold_step);
      @(negedge clk_i);
      rst_i = 1'b1; run_i = 0; step_i = hold_step; instr_done_i = 0;
      #1;
      model_reset();
      check("rst.halt", halt_o, 1);
      check("rst.view", view_o, 1);
      check("rst.state", state_o, 0);
      check("rst.cnt", instr_cnt_o, 0);
      check("rst.bp_hit", bp_hit_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   typedef struct {
      bit run; bit step; int cnt; bit bpen; int bpa; int pc; bit done;
      int e_state; bit e_halt; bit e_view; bit e_bp; int e_cnt;
   } vec_t;

   vec_t vt[25];

   initial begin
      rst_i = 1'b0; run_i = 0; step_i = 0; step_count_i = 0; bp_en_i = 0;
      bp_addr_i = 0; pc_i = 0; instr_done_i = 0;
      model_reset();
      //        run step cnt bpen bpa    pc     done  st halt view bp cnt
      vt[0]  = '{0, 0, 0, 0, 16'h40, 16'h00, 0,  0, 1, 1, 0, 0};
      vt[1]  = '{0, 1, 0, 0, 16'h40, 16'h00, 0,  1, 0, 0, 0, 0};
      vt[2]  = '{0, 1, 0, 0, 16'h40, 16'h05, 1,  3, 1, 0, 0, 1};
      vt[3]  = '{0, 1, 0, 0, 16'h40, 16'h00, 0,  3, 1, 0, 0, 1};
      vt[4]  = '{0, 0, 0, 0, 16'h40, 16'h00, 0,  0, 1, 1, 0, 1};
      vt[5]  = '{0, 1, 3, 0, 16'h40, 16'h00, 0,  1, 0, 0, 0, 0};
      vt[6]  = '{0, 1, 3, 0, 16'h40, 16'h01, 1,  1, 0, 0, 0, 1};
      vt[7]  = '{0, 0, 3, 0, 16'h40, 16'h00, 0,  1, 0, 0, 0, 1};
      vt[8]  = '{1, 0, 3, 0, 16'h40, 16'h02, 1,  1, 0, 0, 0, 2};
      vt[9]  = '{0, 1, 3, 0, 16'h40, 16'h00, 0,  1, 0, 0, 0, 2};
      vt[10] = '{0, 0, 3, 0, 16'h40, 16'h03, 1,  3, 1, 0, 0, 3};
      vt[11] = '{0, 0, 3, 0, 16'h40, 16'h00, 0,  0, 1, 1, 0, 3};
      vt[12] = '{0, 0, 3, 1, 16'h40, 16'h40, 1,  0, 1, 1, 0, 3};
      vt[13] = '{1, 0, 0, 0, 16'h40, 16'h00, 0,  2, 0, 0, 0, 0};
      vt[14] = '{1, 0, 0, 1, 16'h40, 16'h40, 1,  3, 1, 0, 1, 1};
      vt[15] = '{1, 0, 0, 1, 16'h40, 16'h00, 0,  3, 1, 0, 1, 1};
      vt[16] = '{0, 0, 0, 1, 16'h40, 16'h00, 0,  0, 1, 1, 1, 1};
      vt[17] = '{0, 1, 2, 0, 16'h40, 16'h00, 0,  1, 0, 0, 0, 0};
      vt[18] = '{0, 1, 2, 0, 16'h40, 16'h40, 1,  1, 0, 0, 0, 1};
      vt[19] = '{0, 0, 2, 1, 16'h40, 16'h41, 1,  3, 1, 0, 0, 2};
      vt[20] = '{0, 0, 2, 0, 16'h40, 16'h00, 0,  0, 1, 1, 0, 2};
      vt[21] = '{1, 1, 2, 0, 16'h40, 16'h00, 0,  1, 0, 0, 0, 0};
      vt[22] = '{1, 1, 2, 1, 16'h40, 16'h40, 1,  3, 1, 0, 1, 1};
      vt[23] = '{0, 1, 2, 0, 16'h40, 16'h00, 0,  3, 1, 0, 1, 1};
      vt[24] = '{0, 0, 2, 0, 16'h40, 16'h00, 0,  0, 1, 1, 1, 1};

      do_reset(1'b0);
      for (int i = 0; i < 25; i++) begin
         apply($sformatf("vec%0d", i), vt[i].run, vt[i].step, vt[i].cnt, vt[i].bpen,
               vt[i].bpa, vt[i].pc, vt[i].done);
         check($sformatf("vec%0d.state", i), state_o, vt[i].e_state);
         check($sformatf("vec%0d.halt", i), halt_o, vt[i].e_halt);
         check($sformatf("vec%0d.view", i), view_o, vt[i].e_view);
         check($sformatf("vec%0d.bp", i), bp_hit_o, vt[i].e_bp);
         check($sformatf("vec%0d.cnt", i), instr_cnt_o, vt[i].e_cnt);
         $display("vec%0d: state=%0d halt=%0d view=%0d bp=%0d cnt=%0d", i, state_o, halt_o,
                  view_o, bp_hit_o, instr_cnt_o);
      end

      // Reset mid-RUN after three retired instructions, with the step button held through it
      apply("run_go", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) apply("run_ins", 1, 0, 0, 0, 0, i, 1);
      check("run3.cnt", instr_cnt_o, 3);
      do_reset(1'b1);
      apply("held1", 0, 1, 1, 0, 0, 0, 0);
      apply("held2", 0, 1, 1, 0, 0, 0, 0);
      check("held.state", state_o, 0);
      apply("rel", 0, 0, 1, 0, 0, 0, 0);
      apply("press", 0, 1, 1, 0, 0, 0, 0);
      check("press.state", state_o, 1);
      apply("press_done", 0, 1, 1, 0, 0, 0, 1);
      apply("press_rel", 0, 0, 1, 0, 0, 0, 0);
      $display("reset/held-step sequence: state=%0d", state_o);

      // run_i falls mid-instruction: keep running until that instruction retires
      apply("r4_go", 1, 0, 0, 0, 0, 0, 0);
      apply("r4_fall", 0, 0, 0, 0, 0, 0, 0);
      apply("r4_mid", 0, 0, 0, 0, 0, 0, 0);
      check("r4_mid.halt", halt_o, 0);
      apply("r4_done", 0, 0, 0, 0, 0, 0, 1);
      check("r4_done.halt", halt_o, 1);
      check("r4_done.state", state_o, 3);
      apply("r4_idle", 0, 0, 0, 0, 0, 0, 1);
      check("r4_idle.cnt", instr_cnt_o, 1);
      $display("run-fall sequence: state=%0d cnt=%0d", state_o, instr_cnt_o);

      // Retired-instruction counter saturation
      apply("sat_go", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 260; i++) apply("sat", 1, 0, 0, 0, 0, 0, 1);
      check("sat.cnt", instr_cnt_o, 255);
      apply("sat_stop", 0, 0, 0, 0, 0, 0, 1);
      apply("sat_idle", 0, 0, 0, 0, 0, 0, 0);
      $display("saturation sequence: cnt=%0d", instr_cnt_o);

      // Randomized stimulus against the model
      begin
         bit r_run = 0;
         bit r_step = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
               do_reset($urandom_range(0, 1) == 1);
               r_step = step_i;
            end
            if ($urandom_range(0, 9) == 0) r_run = ~r_run;
            if ($urandom_range(0, 3) == 0) r_step = ~r_step;
            apply("rnd", r_run, r_step, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                  16'h40, $urandom_range(16'h3E, 16'h41), $urandom_range(0, 2) == 0);
            if (i % 500 == 0)
               $display("rnd%0d: state=%0d cnt=%0d bp=%0d", i, state_o, instr_cnt_o, bp_hit_o);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
